// File: rtl/fp_add_pkg.sv
// Shared widths, mantissa bit positions and FSM states for the FP adder datapath.
package fp_add_pkg;

  localparam int EXP_W   = 8;
  localparam int MANT_W  = 28;
  localparam int RES_W   = 32;

  localparam int OVF     = 27;
  localparam int HID     = 26;
  localparam int FRAC_HI = 25;
  localparam int FRAC_LO = 3;
  localparam int G       = 2;
  localparam int R       = 1;
  localparam int S       = 0;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a normalized internal mantissa; renormalizes on carry-out.
module fp_rne_round
  import fp_add_pkg::*;
(
  input  logic [MANT_W-1:0] m,
  input  logic [EXP_W:0]    e,
  output logic [MANT_W-1:0] m_out,
  output logic [EXP_W:0]    e_out,
  output logic              ovf
);

  logic                        inc;
  logic [MANT_W-FRAC_LO-1:0]   upper;
  logic [MANT_W-1:0]           m_inc;

  // Increment only above half an ulp, or exactly half with an odd LSB.
  always_comb begin
    inc   = m[G] & (m[FRAC_LO] | m[R] | m[S]);
    upper = m[MANT_W-1:FRAC_LO] + {{(MANT_W-FRAC_LO-1){1'b0}}, inc};
    m_inc = {upper, m[G:S]};
    if (m_inc[OVF]) begin
      m_out = {1'b0, m_inc[MANT_W-1:1]};
      e_out = e + 9'd1;
    end else begin
      m_out = m_inc;
      e_out = e;
    end
    ovf = (e_out >= {1'b0, EXP_MAX});
  end

endmodule

// File: rtl/fp_norm_pack.sv
// FP adder back end: add/subtract ordered mantissas, normalize one shift per cycle,
// round to nearest-even and pack an IEEE-754 single, with valid/ready on both sides.
module fp_norm_pack
  import fp_add_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              Comp,
  input  logic              SA,
  input  logic              SB,
  input  logic [EXP_W-1:0]  EO,
  input  logic [MANT_W-1:0] MA,
  input  logic [MANT_W-1:0] MB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  res
);

  state_t            state;
  logic              comp_q, sa_q, sb_q, sign;
  logic [MANT_W-1:0] ma_q, mb_q, m, m_add, m_rnd;
  logic [EXP_W:0]    e, e_rnd;
  logic              rnd_ovf;

  // Operands are pre-ordered (MA >= MB), so the difference never goes negative.
  always_comb begin
    m_add = (sa_q == sb_q) ? (ma_q + mb_q) : (ma_q - mb_q);
  end

  fp_rne_round u_round (
    .m     (m),
    .e     (e),
    .m_out (m_rnd),
    .e_out (e_rnd),
    .ovf   (rnd_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      comp_q    <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      sign      <= 1'b0;
      ma_q      <= '0;
      mb_q      <= '0;
      m         <= '0;
      e         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            comp_q   <= Comp;
            sa_q     <= SA;
            sb_q     <= SB;
            ma_q     <= MA;
            mb_q     <= MB;
            e        <= (EO == '0) ? 9'd1 : {1'b0, EO};
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end
        ADD: begin
          m    <= m_add;
          sign <= (sa_q == sb_q) ? sa_q : (comp_q ? sa_q : sb_q);
          if (m_add == '0) begin
            res       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= NORM;
          end
        end
        // Right shift keeps the dropped bit as sticky; left shifts stop at the denormal floor.
        NORM: begin
          if (m[OVF]) begin
            m <= {1'b0, m[MANT_W-1:2], m[R] | m[S]};
            e <= e + 9'd1;
          end else if (!m[HID] && (e > 9'd1)) begin
            m <= {m[MANT_W-2:0], 1'b0};
            e <= e - 9'd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          m <= m_rnd;
          e <= e_rnd;
          if (rnd_ovf)
            res <= {sign, EXP_MAX, 23'h0};
          else if (!m_rnd[HID])
            res <= {sign, {EXP_W{1'b0}}, m_rnd[FRAC_HI:FRAC_LO]};
          else
            res <= {sign, e_rnd[EXP_W-1:0], m_rnd[FRAC_HI:FRAC_LO]};
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_pack.sv
// Randomized self-checking bench for fp_norm_pack against an arithmetic reference model.
module tb_fp_norm_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        Comp = 1'b0, SA = 1'b0, SB = 1'b0;
  logic [7:0]  EO = '0;
  logic [27:0] MA = '0, MB = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;

  int checks = 0;
  int failures = 0;

  fp_norm_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Comp      (Comp),
    .SA        (SA),
    .SB        (SB),
    .EO        (EO),
    .MA        (MA),
    .MB        (MB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, expected);
    end
  endtask

  // Reference: exact integer arithmetic, leading-one search, then RNE on the integer quotient.
  function automatic void model(input logic comp, input logic sa, input logic sb,
                                input logic [7:0] eo, input logic [27:0] ma, input logic [27:0] mb,
                                output logic [31:0] r, output int lat);
    int          e, msb, sh;
    logic [63:0] m, q, rem;
    logic        sg;
    e = (eo == 8'd0) ? 1 : int'(eo);
    if (sa == sb) begin
      m  = 64'(ma) + 64'(mb);
      sg = sa;
    end else begin
      m  = 64'(ma) - 64'(mb);
      sg = comp ? sa : sb;
    end
    if (m == 64'd0) begin
      r   = 32'h0;
      lat = 2;
      return;
    end
    if (m >= (64'd1 << 27)) begin
      m   = (m >> 1) | (m & 64'd1);
      e   = e + 1;
      lat = 5;
    end else begin
      msb = 0;
      for (int i = 0; i < 27; i++) if (m[i]) msb = i;
      sh = 26 - msb;
      if (sh > e - 1) sh = e - 1;
      m   = m << sh;
      e   = e - sh;
      lat = 4 + sh;
    end
    q   = m >> 3;
    rem = m & 64'd7;
    if (rem > 64'd4 || (rem == 64'd4 && q[0])) q = q + 64'd1;
    if (q >= (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255)
      r = {sg, 8'hFF, 23'h0};
    else if (q < (64'd1 << 23))
      r = {sg, 8'h00, q[22:0]};
    else
      r = {sg, 8'(e), q[22:0]};
  endfunction

  task automatic applyStimulus(input logic comp, input logic sa, input logic sb,
                               input logic [7:0] eo, input logic [27:0] ma, input logic [27:0] mb,
                               input int hold);
    logic [31:0] exp_res;
    int          exp_lat, cnt, guard;
    logic        seen;
    model(comp, sa, sb, eo, ma, mb, exp_res, exp_lat);
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    Comp = comp; SA = sa; SB = sb; EO = eo; MA = ma; MB = mb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Garbage offered while busy must be ignored.
    in_valid = 1'($urandom_range(0, 1));
    Comp = 1'($urandom); SA = 1'($urandom); SB = 1'($urandom);
    EO = 8'($urandom); MA = 28'($urandom); MB = 28'($urandom);
    cnt  = 1;
    seen = 1'b0;
    while (cnt < 60) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cnt++;
    end
    in_valid = 1'b0;
    checkOutput("done_seen", 32'(seen), 32'd1);
    checkOutput("latency", 32'(cnt), 32'(exp_lat));
    checkOutput("res", res, exp_res);
    checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
    repeat (hold) begin
      @(negedge clk);
      checkOutput("hold_res", res, exp_res);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("release_valid", 32'(out_valid), 32'd0);
    checkOutput("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [27:0] ma, mb;
    logic [7:0]  eo;
    int          p, k, sel;

    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_res", res, 32'h0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0, 8'd127, 28'h4000000, 28'h4000000, 10);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd127, 28'h6000000, 28'h4000000, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd127, 28'h5000000, 28'h5000000, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd127, 28'h4000004, 28'h0000000, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd127, 28'h400000C, 28'h0000000, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd254, 28'h7FFFFF8, 28'h7FFFFF8, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd3,   28'h0000123, 28'h0000011, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0,   28'h3FFFFFC, 28'h0000004, 0);

    // Abort an operation mid-normalization and confirm a clean return to idle.
    @(negedge clk);
    Comp = 1'b1; SA = 1'b0; SB = 1'b0; EO = 8'd127; MA = 28'h0000100; MB = 28'h0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midnorm_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("midnorm_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("midnorm_rst_res", res, 32'h0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b1, 8'd127, 28'h6000000, 28'h4000000, 0);

    for (int n = 0; n < 250; n++) begin
      p  = $urandom_range(0, 26);
      ma = (28'($urandom) & ((28'd1 << (p + 1)) - 28'd1)) | (28'd1 << p);
      sel = $urandom_range(0, 3);
      case (sel)
        0: mb = ma;
        1: begin k = $urandom_range(0, 27); mb = ma >> k; end
        2: mb = 28'($urandom) % (ma + 28'd1);
        default: mb = ma - 28'($urandom_range(0, 8)) > ma ? 28'd0 : ma - 28'($urandom_range(0, 8));
      endcase
      if (mb > ma) mb = ma;
      sel = $urandom_range(0, 5);
      case (sel)
        0: eo = 8'($urandom_range(0, 3));
        1: eo = 8'($urandom_range(250, 255));
        default: eo = 8'($urandom);
      endcase
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), eo, ma, mb, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
